// File: rtl/aes_inv_key_expander.sv
// AES-128 reverse key schedule: starts from the round-10 key and emits round keys 10 down to 0,
// rebuilding one 32-bit word per cycle in place with a single 4-byte S-box lookup.
//
// state | meaning
// IDLE  | waiting for start
// EMIT  | round key presented, held until rk_ready_i
// CALC  | rebuilding the previous round key, word j = 3,2,1,0
module aes_inv_key_expander (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start_i,
    input  logic [127:0] key_i,
    input  logic         abort_i,
    input  logic         rk_ready_i,
    output logic [127:0] rk_o,
    output logic [3:0]   rk_round_o,
    output logic         rk_valid_o,
    output logic         busy_o,
    output logic         done_o
);

    typedef enum logic [1:0] {IDLE, EMIT, CALC} state_e;

    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [10:0] hi;
        hi = 11'd2047 - {x, 3'b000};
        return SBOX_TBL[hi -: 8];
    endfunction

    // Inverse of xtime in GF(2^8): steps the round constant backwards.
    function automatic logic [7:0] inv_xtime(input logic [7:0] x);
        logic [8:0] t;
        t = {1'b0, x} ^ 9'h11b;
        return x[0] ? t[8:1] : {1'b0, x[7:1]};
    endfunction

    state_e      state_q, state_d;
    logic [31:0] w_q [4];
    logic [31:0] w_d [4];
    logic [1:0]  j_q, j_d;
    logic [7:0]  rc_q, rc_d;
    logic [3:0]  round_q, round_d;
    logic [31:0] rot_w3, sub_w3;

    // W3 already holds its new value by the time j reaches 0.
    assign rot_w3 = {w_q[3][23:0], w_q[3][31:24]};
    assign sub_w3 = {sbox(rot_w3[31:24]), sbox(rot_w3[23:16]), sbox(rot_w3[15:8]), sbox(rot_w3[7:0])};

    always_comb begin
        state_d = state_q;
        w_d     = w_q;
        j_d     = j_q;
        rc_d    = rc_q;
        round_d = round_q;
        done_o  = 1'b0;
        if (abort_i) begin
            state_d = IDLE;
            j_d     = 2'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        w_d[0]  = key_i[127:96];
                        w_d[1]  = key_i[95:64];
                        w_d[2]  = key_i[63:32];
                        w_d[3]  = key_i[31:0];
                        round_d = 4'd10;
                        rc_d    = 8'h36;
                        j_d     = 2'd0;
                        state_d = EMIT;
                    end
                end
                EMIT: begin
                    if (rk_ready_i) begin
                        if (round_q == 4'd0) begin
                            state_d = IDLE;
                            done_o  = 1'b1;
                        end else begin
                            state_d = CALC;
                            j_d     = 2'd3;
                        end
                    end
                end
                CALC: begin
                    j_d = j_q - 2'd1;
                    case (j_q)
                        2'd3: w_d[3] = w_q[3] ^ w_q[2];
                        2'd2: w_d[2] = w_q[2] ^ w_q[1];
                        2'd1: w_d[1] = w_q[1] ^ w_q[0];
                        default: begin
                            w_d[0]  = w_q[0] ^ sub_w3 ^ {rc_q, 24'h0};
                            round_d = round_q - 4'd1;
                            rc_d    = inv_xtime(rc_q);
                            state_d = EMIT;
                        end
                    endcase
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            w_q[0]  <= '0;
            w_q[1]  <= '0;
            w_q[2]  <= '0;
            w_q[3]  <= '0;
            j_q     <= '0;
            rc_q    <= '0;
            round_q <= '0;
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
            j_q     <= j_d;
            rc_q    <= rc_d;
            round_q <= round_d;
        end
    end

    assign rk_o       = {w_q[0], w_q[1], w_q[2], w_q[3]};
    assign rk_round_o = round_q;
    assign rk_valid_o = (state_q == EMIT);
    assign busy_o     = (state_q != IDLE);

endmodule
